// File: rtl/bufgmux_sel_ctrl_pkg.sv
// Shared definitions for the clock-mux select sequencer: state encoding,
// counter width and parameter range check helper.
package bufgmux_ctrl_pkg;

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    QUIESCE,
    SETTLE
  } state_t;

  function automatic bit in_range_1_255(input int unsigned v);
    return (v >= 1) && (v <= 255);
  endfunction

endpackage

// File: rtl/bufgmux_sel_ctrl_if.sv
// Request/quiesce handshake bundle between the select sequencer, its
// requester and the downstream logic it holds off.
interface bufgmux_sel_ctrl_if;

  logic REQ;
  logic REQ_SEL;
  logic HOLD_ACK;
  logic S;
  logic HOLD;
  logic BUSY;
  logic DONE;
  logic ERR;

  modport master (
    output REQ, REQ_SEL, HOLD_ACK,
    input  S, HOLD, BUSY, DONE, ERR
  );

  modport slave (
    input  REQ, REQ_SEL, HOLD_ACK,
    output S, HOLD, BUSY, DONE, ERR
  );

endinterface

// File: rtl/bufgmux_sel_ctrl_seq_cnt.sv
// Synchronous-clear, enabled up-counter with a terminal-match flag against
// a programmable limit; shared by the timed states of the sequencer.
module bufgmux_seq_cnt
  import bufgmux_ctrl_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_limit,
  output logic             o_match
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_match = (r_cnt == i_limit);

endmodule

// File: rtl/bufgmux_sel_ctrl.sv
// Select-line sequencer for a global clock mux: quiesce downstream, switch S,
// hold for a settle window, then release and pulse DONE.
module bufgmux_sel_ctrl
  import bufgmux_ctrl_pkg::*;
#(
  parameter bit          INIT_SEL      = 1'b0,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned ACK_TIMEOUT   = 255
) (
  input  logic               CLK,
  input  logic               RST_N,
  bufgmux_sel_ctrl_if.slave  bus
);

  if (!in_range_1_255(SETTLE_CYCLES)) begin : g_bad_settle
    $error("SETTLE_CYCLES must be within 1..255");
  end
  if (!in_range_1_255(ACK_TIMEOUT)) begin : g_bad_timeout
    $error("ACK_TIMEOUT must be within 1..255");
  end

  localparam logic [CNT_W-1:0] SETTLE_LIM = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACK_LIM    = CNT_W'(ACK_TIMEOUT - 1);

  state_t r_state, w_state_nxt;
  logic   r_s, r_hold, r_busy, r_done, r_err, r_tgt;
  logic   w_s_nxt, w_hold_nxt, w_busy_nxt, w_done_nxt, w_err_nxt, w_tgt_nxt;
  logic   w_cnt_clr, w_cnt_en, w_cnt_match;
  logic [CNT_W-1:0] w_limit;

  assign w_limit = (r_state == SETTLE) ? SETTLE_LIM : ACK_LIM;

  bufgmux_seq_cnt u_cnt (
    .i_clk   (CLK),
    .i_rst_n (RST_N),
    .i_clr   (w_cnt_clr),
    .i_en    (w_cnt_en),
    .i_limit (w_limit),
    .o_match (w_cnt_match)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= IDLE;
      r_s     <= INIT_SEL;
      r_hold  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_tgt   <= INIT_SEL;
    end else begin
      r_state <= w_state_nxt;
      r_s     <= w_s_nxt;
      r_hold  <= w_hold_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      r_tgt   <= w_tgt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_s_nxt     = r_s;
    w_hold_nxt  = r_hold;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_err_nxt   = r_err;
    w_tgt_nxt   = r_tgt;
    w_cnt_clr   = 1'b0;
    w_cnt_en    = 1'b0;

    unique case (r_state)
      IDLE: begin
        w_cnt_clr = 1'b1;
        if (bus.REQ) begin
          w_err_nxt = 1'b0;
          if (bus.REQ_SEL != r_s) begin
            w_state_nxt = QUIESCE;
            w_hold_nxt  = 1'b1;
            w_busy_nxt  = 1'b1;
            w_tgt_nxt   = bus.REQ_SEL;
          end else begin
            w_done_nxt  = 1'b1;
          end
        end
      end
      QUIESCE: begin
        // ack is checked before the timeout so a late ack still wins
        if (bus.HOLD_ACK) begin
          w_state_nxt = SETTLE;
          w_s_nxt     = r_tgt;
          w_cnt_clr   = 1'b1;
        end else if (w_cnt_match) begin
          w_state_nxt = IDLE;
          w_hold_nxt  = 1'b0;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_err_nxt   = 1'b1;
          w_cnt_clr   = 1'b1;
        end else begin
          w_cnt_en    = 1'b1;
        end
      end
      SETTLE: begin
        if (w_cnt_match) begin
          w_state_nxt = IDLE;
          w_hold_nxt  = 1'b0;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_cnt_clr   = 1'b1;
        end else begin
          w_cnt_en    = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_clr   = 1'b1;
      end
    endcase
  end

  assign bus.S    = r_s;
  assign bus.HOLD = r_hold;
  assign bus.BUSY = r_busy;
  assign bus.DONE = r_done;
  assign bus.ERR  = r_err;

endmodule

// File: doc/bufgmux_sel_ctrl.md
# bufgmux_sel_ctrl

Sequencer that owns the select line of a global clock multiplexer (BUFGMUX-class primitive, I0/I1/S). It accepts source-switch requests, quiesces the downstream logic through a hold/acknowledge handshake, drives the select, waits a settle interval, then releases the logic and reports completion. It sits in the always-on control clock domain, beside the clock mux it controls.

## Interface

Parameters:
- INIT_SEL, 0: select value driven out of reset (0 = I0, 1 = I1).
- SETTLE_CYCLES, 8: cycles S is held stable with HOLD asserted after a switch; legal range 1..255.
- ACK_TIMEOUT, 255: maximum cycles in QUIESCE waiting for HOLD_ACK; legal range 1..255.

Ports:
- CLK  input  1  control clock. This is the only clock; the block never runs on the muxed clock.
- RST_N  input  1  reset, synchronous and active-low.
- REQ  input  1  switch request, sampled only when BUSY=0.
- REQ_SEL  input  1  target select, captured with REQ.
- HOLD_ACK  input  1  downstream confirms it is quiescent.
- S  output  1  registered select to the clock mux.
- HOLD  output  1  quiesce request to downstream.
- BUSY  output  1  a request is in progress.
- DONE  output  1  one-cycle completion pulse.
- ERR  output  1  last request timed out; sticky.

## Operation

- States: IDLE, QUIESCE, SETTLE. One 8-bit counter CNT is shared by both timed states.
- Reset values (RST_N=0 at an edge): state=IDLE, S=INIT_SEL, HOLD=0, BUSY=0, DONE=0, ERR=0, CNT=0.
- IDLE, REQ=1, REQ_SEL≠S: go to QUIESCE. HOLD=1, BUSY=1, ERR=0, CNT=0, target latched.
- IDLE, REQ=1, REQ_SEL==S (no-op): stay in IDLE. DONE=1 for one cycle, ERR=0. HOLD and S are unchanged.
- QUIESCE, HOLD_ACK=1: go to SETTLE. S=target at the same edge, CNT=0.
- QUIESCE, HOLD_ACK=0, CNT==ACK_TIMEOUT-1: go to IDLE. HOLD=0, BUSY=0, DONE=1, ERR=1. S is unchanged.
- QUIESCE otherwise: CNT+1.
- SETTLE, CNT==SETTLE_CYCLES-1: go to IDLE. HOLD=0, BUSY=0, DONE=1.
- SETTLE otherwise: CNT+1. HOLD_ACK is ignored in this state.
- REQ while BUSY=1 is ignored and not queued. The requester re-issues after BUSY falls.
- ERR stays high until the next accepted REQ clears it.
- S changes only on the QUIESCE→SETTLE edge, and HOLD is always 1 on that edge. Reset is the one exception: RST_N low mid-operation forces S=INIT_SEL and HOLD=0 at the next edge.

## Timing

- All outputs are registered. No combinational path from inputs to outputs.
- Normal switch: REQ sampled at edge e0. HOLD and BUSY are high after e0. HOLD_ACK sampled high at e1 switches S after e1. DONE is high, and HOLD and BUSY are low, after edge e1+SETTLE_CYCLES.
- HOLD stays high for exactly 1+SETTLE_CYCLES cycles when HOLD_ACK is already high.
- No-op request: DONE is high in the cycle after e0. BUSY never rises.
- Timeout: HOLD is high for exactly ACK_TIMEOUT cycles, then DONE and ERR rise together.
- Back-to-back: BUSY=0 in the DONE cycle, so a REQ sampled at the edge ending the DONE cycle is accepted.
- HOLD_ACK arriving on the same edge where CNT==ACK_TIMEOUT-1: the ack wins and the switch proceeds.

## Structure

- Shared package bufgmux_ctrl_pkg holds:
  - the state encoding IDLE/QUIESCE/SETTLE;
  - CNT_W=8;
  - parameter range checks: elaboration error if SETTLE_CYCLES or ACK_TIMEOUT is outside 1..255.
- One sub-module, bufgmux_seq_cnt: a synchronous-clear, enabled 8-bit up-counter with a terminal-match output against a programmable limit. The FSM instantiates it once and selects the limit by state.

## Test plan

- Reset: INIT_SEL=1, RST_N low for 2 edges → S=1, HOLD=0, BUSY=0, DONE=0, ERR=0.
- Switch: SETTLE_CYCLES=8, HOLD_ACK tied high, REQ with REQ_SEL=1 from S=0 at e0 →
  - HOLD high after e0;
  - S=1 after e1;
  - DONE is a single pulse after e9, with HOLD=0 and BUSY=0.
- Delayed ack: HOLD_ACK rises 5 cycles after HOLD → S toggles on the edge sampling the ack; the settle window is still 8 cycles.
- Timeout: ACK_TIMEOUT=16, HOLD_ACK held low → HOLD high for 16 cycles, then DONE=1 and ERR=1 with S unchanged. The next accepted REQ clears ERR.
- No-op and busy: REQ_SEL==S → DONE pulses next cycle with no HOLD. A REQ pulsed during SETTLE → ignored and S unchanged afterwards.
- Reset mid-SETTLE: RST_N low at cycle 3 of SETTLE → next edge gives S=INIT_SEL, HOLD=0, BUSY=0, no DONE.
